// File: rtl/arm32_mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the single-port RAM.
// Handshakes: a request is held stable until its gnt; a response is held until its rready (transfer on rvalid && rready).
interface arm32_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_f_req;
    logic [AW-1:0] i_f_addr;
    logic          o_f_gnt;
    logic          o_f_rvalid;
    logic [DW-1:0] o_f_rdata;
    logic          i_f_rready;
    logic          i_d_req;
    logic          i_d_we;
    logic [AW-1:0] i_d_addr;
    logic [DW-1:0] i_d_wdata;
    logic          o_d_gnt;
    logic          o_d_rvalid;
    logic [DW-1:0] o_d_rdata;
    logic          i_d_rready;
    logic          o_m_en;
    logic          o_m_we;
    logic [AW-3:0] o_m_addr;
    logic [DW-1:0] o_m_wdata;
    logic [DW-1:0] i_m_rdata;
    logic          o_busy;

    modport slave (
        input  i_f_req, i_f_addr, i_f_rready,
        input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_rready,
        input  i_m_rdata,
        output o_f_gnt, o_f_rvalid, o_f_rdata,
        output o_d_gnt, o_d_rvalid, o_d_rdata,
        output o_m_en, o_m_we, o_m_addr, o_m_wdata, o_busy
    );

    modport master (
        output i_f_req, i_f_addr, i_f_rready,
        output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_rready,
        output i_m_rdata,
        input  o_f_gnt, o_f_rvalid, o_f_rdata,
        input  o_d_gnt, o_d_rvalid, o_d_rdata,
        input  o_m_en, o_m_we, o_m_addr, o_m_wdata, o_busy
    );
endinterface

// File: rtl/arm32_mem_arbiter.sv
// Fetch/data arbiter for the shared single-port RAM: data has priority, a streak
// counter lets a waiting fetch in after STARVE_MAX back-to-back data grants.
module arm32_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    arm32_mem_arbiter_if.slave bus,
    output logic [1:0]         o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);
    localparam logic [2:0] LAT        = 3'(RD_LAT);

    state_e        state_q, state_d;
    logic [3:0]    streak_q, streak_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;  // 1 = data, 0 = fetch
    logic          we_q, we_d;
    logic [AW-3:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] f_rdata_q, f_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          d_win, f_win;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{bus.i_f_addr[1:0], bus.i_d_addr[1:0]};

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        d_win     = 1'b0;
        f_win     = 1'b0;
        case (state_q)
            S_IDLE: begin
                d_win = bus.i_d_req && !(bus.i_f_req && streak_q == STREAK_MAX);
                f_win = bus.i_f_req && !d_win;
                if (d_win) begin
                    owner_d  = 1'b1;
                    we_d     = bus.i_d_we;
                    addr_d   = bus.i_d_addr[AW-1:2];
                    wdata_d  = bus.i_d_wdata;
                    streak_d = !bus.i_f_req ? 4'd0 :
                               (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
                    state_d  = S_ACCESS;
                end else if (f_win) begin
                    owner_d  = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = bus.i_f_addr[AW-1:2];
                    streak_d = 4'd0;
                    state_d  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Stores commit in this cycle and produce no response.
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = 3'd1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAT) begin
                    if (owner_q) d_rdata_d = bus.i_m_rdata;
                    else         f_rdata_d = bus.i_m_rdata;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RESP: begin
                if (owner_q ? bus.i_d_rready : bus.i_f_rready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            streak_q  <= 4'd0;
            cnt_q     <= 3'd0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Grants are combinational, so they are also masked while reset is asserted.
    assign bus.o_f_gnt    = f_win && !reset;
    assign bus.o_d_gnt    = d_win && !reset;
    assign bus.o_f_rvalid = (state_q == S_RESP) && !owner_q;
    assign bus.o_d_rvalid = (state_q == S_RESP) && owner_q;
    assign bus.o_f_rdata  = f_rdata_q;
    assign bus.o_d_rdata  = d_rdata_q;
    assign bus.o_m_en     = (state_q == S_ACCESS);
    assign bus.o_m_we     = (state_q == S_ACCESS) && we_q;
    assign bus.o_m_addr   = addr_q;
    assign bus.o_m_wdata  = wdata_q;
    assign bus.o_busy     = (state_q != S_IDLE);
    assign o_dbg_state    = state_q;
endmodule

// File: tb/tb_arm32_mem_arbiter.sv
// Bench for arm32_mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of arbitration, timing and RAM contents.
module tb_arm32_mem_arbiter;
    localparam logic [31:0] POISON = 32'h0BAD_F00D;
    localparam int          SM     = 4;
    localparam int          LAT_A  = 1;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_a;
    logic [1:0] dbg_b;
    int         checks;
    int         failures;

    arm32_mem_arbiter_if #(.AW(32), .DW(32)) ba ();
    arm32_mem_arbiter_if #(.AW(32), .DW(32)) bb ();

    arm32_mem_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .reset(reset), .bus(ba.slave), .o_dbg_state(dbg_a)
    );
    arm32_mem_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .reset(reset), .bus(bb.slave), .o_dbg_state(dbg_b)
    );

    function automatic logic [31:0] mem_init(input int i);
        if (i == 4) return 32'hE3A0_1005;
        if (i == 5) return 32'h1234_5678;
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM models: contents reload on reset, read data appears RD_LAT cycles after enable
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= mem_init(i);
        end else if (ba.o_m_en && ba.o_m_we) begin
            mem_a[ba.o_m_addr[7:0]] <= ba.o_m_wdata;
        end
        pipe_a <= ba.o_m_en ? mem_a[ba.o_m_addr[7:0]] : POISON;
    end
    assign ba.i_m_rdata = pipe_a;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= mem_init(i);
        end else if (bb.o_m_en && bb.o_m_we) begin
            mem_b[bb.o_m_addr[7:0]] <= bb.o_m_wdata;
        end
        pipe_b[0] <= bb.o_m_en ? mem_b[bb.o_m_addr[7:0]] : POISON;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign bb.i_m_rdata = pipe_b[2];

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ba.i_f_req = 0; ba.i_f_addr = 0; ba.i_f_rready = 0;
        ba.i_d_req = 0; ba.i_d_we = 0; ba.i_d_addr = 0; ba.i_d_wdata = 0; ba.i_d_rready = 0;
        bb.i_f_req = 0; bb.i_f_addr = 0; bb.i_f_rready = 0;
        bb.i_d_req = 0; bb.i_d_we = 0; bb.i_d_addr = 0; bb.i_d_wdata = 0; bb.i_d_rready = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        smp();
        while (ba.o_busy && c < 20) begin
            cyc();
            smp();
            c++;
        end
        chk(tag, ba.o_busy, 1'b0);
    endtask

    // scoreboard state for the randomized run
    logic [31:0] ref_mem [16];
    logic [31:0] exp_q [$];
    bit          exp_seq [10];
    int          ng, seen, streak_m, busy_until, resp_due, acc_at, acc_word, win;
    int          f_word, d_word;
    bit          rd_out, rd_d, acc_we, fp, dp, free_m, exp_f_rv, exp_d_rv, d_we_v;
    logic [31:0] d_wdata_v, acc_wdata;

    initial begin
        checks   = 0;
        failures = 0;
        do_reset();
        smp();
        chk("rst_busy", ba.o_busy, 1'b0);
        chk("rst_m_en", ba.o_m_en, 1'b0);

        // single fetch, RD_LAT=1
        cyc();
        ba.i_f_req = 1; ba.i_f_addr = 32'h0000_0010; ba.i_f_rready = 1;
        smp();
        chk("t1_f_gnt", ba.o_f_gnt, 1'b1);
        chk("t1_d_gnt", ba.o_d_gnt, 1'b0);
        cyc();
        ba.i_f_req = 0;
        smp();
        chk("t1_m_en", ba.o_m_en, 1'b1);
        chk("t1_m_we", ba.o_m_we, 1'b0);
        chk("t1_m_addr", ba.o_m_addr, 30'd4);
        chk("t1_busy", ba.o_busy, 1'b1);
        cyc(); smp();
        chk("t1_rvalid_c2", ba.o_f_rvalid, 1'b0);
        chk("t1_m_en_c2", ba.o_m_en, 1'b0);
        cyc(); smp();
        chk("t1_rvalid_c3", ba.o_f_rvalid, 1'b1);
        chk("t1_rdata", ba.o_f_rdata, 32'hE3A0_1005);
        chk("t1_d_rvalid", ba.o_d_rvalid, 1'b0);
        cyc(); smp();
        chk("t1_rvalid_c4", ba.o_f_rvalid, 1'b0);
        chk("t1_idle", ba.o_busy, 1'b0);

        // store then misaligned load
        cyc();
        ba.i_d_req = 1; ba.i_d_we = 1; ba.i_d_addr = 32'h20; ba.i_d_wdata = 32'hDEAD_BEEF;
        ba.i_d_rready = 1;
        smp();
        chk("t2_st_gnt", ba.o_d_gnt, 1'b1);
        cyc();
        ba.i_d_req = 0;
        smp();
        chk("t2_st_m_en", ba.o_m_en, 1'b1);
        chk("t2_st_m_we", ba.o_m_we, 1'b1);
        chk("t2_st_m_addr", ba.o_m_addr, 30'd8);
        chk("t2_st_m_wdata", ba.o_m_wdata, 32'hDEAD_BEEF);
        chk("t2_st_rvalid", ba.o_d_rvalid, 1'b0);
        cyc();
        ba.i_d_req = 1; ba.i_d_we = 0; ba.i_d_addr = 32'h23;
        smp();
        chk("t2_ld_gnt", ba.o_d_gnt, 1'b1);
        cyc();
        ba.i_d_req = 0;
        for (int i = 1; i <= 4; i++) begin
            smp();
            chk($sformatf("t2_ld_rvalid_%0d", i), ba.o_d_rvalid, (i == 3));
            if (i == 3) chk("t2_ld_rdata", ba.o_d_rdata, 32'hDEAD_BEEF);
            chk($sformatf("t2_st_no_rvalid_%0d", i), ba.o_f_rvalid, 1'b0);
            cyc();
        end

        // starvation guard: both requesting every cycle, data stores only
        exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        ba.i_f_req = 1; ba.i_f_addr = 32'h10; ba.i_f_rready = 1;
        ba.i_d_req = 1; ba.i_d_we = 1; ba.i_d_addr = 32'h40; ba.i_d_wdata = 32'h5555_AAAA;
        ng = 0;
        for (int c = 0; c < 80 && ng < 10; c++) begin
            smp();
            chk("t3_one_gnt", ba.o_f_gnt & ba.o_d_gnt, 1'b0);
            if (ba.o_f_gnt || ba.o_d_gnt) begin
                chk($sformatf("t3_grant_%0d_is_data", ng), ba.o_d_gnt, exp_seq[ng]);
                ng++;
            end
            cyc();
        end
        chk("t3_grant_count", 64'(ng), 64'd10);
        ba.i_f_req = 0; ba.i_d_req = 0;
        wait_idle("t3_drain");

        // backpressure on a load
        cyc();
        ba.i_d_req = 1; ba.i_d_we = 0; ba.i_d_addr = 32'h20; ba.i_d_rready = 0;
        smp();
        chk("t4_ld_gnt", ba.o_d_gnt, 1'b1);
        cyc();
        ba.i_d_req = 0; ba.i_f_req = 1; ba.i_f_addr = 32'h10; ba.i_f_rready = 1;
        smp();
        chk("t4_no_f_gnt_access", ba.o_f_gnt, 1'b0);
        cyc(); smp();
        chk("t4_no_f_gnt_wait", ba.o_f_gnt, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(); smp();
            chk($sformatf("t4_hold_rvalid_%0d", i), ba.o_d_rvalid, 1'b1);
            chk($sformatf("t4_hold_rdata_%0d", i), ba.o_d_rdata, 32'hDEAD_BEEF);
            chk($sformatf("t4_hold_busy_%0d", i), ba.o_busy, 1'b1);
            chk($sformatf("t4_hold_f_gnt_%0d", i), ba.o_f_gnt, 1'b0);
        end
        cyc();
        ba.i_d_rready = 1;
        smp();
        chk("t4_hs_rvalid", ba.o_d_rvalid, 1'b1);
        chk("t4_hs_f_gnt", ba.o_f_gnt, 1'b0);
        cyc(); smp();
        chk("t4_after_rvalid", ba.o_d_rvalid, 1'b0);
        chk("t4_after_f_gnt", ba.o_f_gnt, 1'b1);
        cyc();
        ba.i_f_req = 0;
        seen = 0;
        for (int c = 0; c < 8 && seen == 0; c++) begin
            smp();
            if (ba.o_f_rvalid) begin
                seen = 1;
                chk("t4_f_rdata", ba.o_f_rdata, 32'hE3A0_1005);
            end
            cyc();
        end
        chk("t4_f_rvalid_seen", 64'(seen), 64'd1);

        // RD_LAT=3 fetch
        bb.i_f_req = 1; bb.i_f_addr = 32'h14; bb.i_f_rready = 1;
        smp();
        chk("t5_gnt", bb.o_f_gnt, 1'b1);
        cyc();
        bb.i_f_req = 0;
        smp();
        chk("t5_m_en", bb.o_m_en, 1'b1);
        chk("t5_m_addr", bb.o_m_addr, 30'd5);
        for (int i = 2; i <= 6; i++) begin
            cyc(); smp();
            chk($sformatf("t5_rvalid_t%0d", i), bb.o_f_rvalid, (i == 5));
            chk($sformatf("t5_busy_t%0d", i), bb.o_busy, (i <= 5));
            if (i == 5) chk("t5_rdata", bb.o_f_rdata, 32'h1234_5678);
        end

        // asynchronous reset while waiting for read data
        cyc();
        ba.i_f_req = 1; ba.i_f_addr = 32'h10; ba.i_f_rready = 1;
        smp();
        chk("t6_gnt", ba.o_f_gnt, 1'b1);
        cyc();
        ba.i_f_req = 0;
        smp();
        cyc(); smp();
        chk("t6_busy_wait", ba.o_busy, 1'b1);
        #2;
        ba.i_d_req = 1; ba.i_d_we = 0; ba.i_d_addr = 32'h24; ba.i_d_rready = 1;
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", ba.o_busy, 1'b0);
        chk("t6_rst_state", dbg_a, 2'd0);
        chk("t6_rst_d_gnt", ba.o_d_gnt, 1'b0);
        chk("t6_rst_f_gnt", ba.o_f_gnt, 1'b0);
        chk("t6_rst_f_rvalid", ba.o_f_rvalid, 1'b0);
        chk("t6_rst_f_rdata", ba.o_f_rdata, 32'h0);
        chk("t6_rst_d_rdata", ba.o_d_rdata, 32'h0);
        chk("t6_rst_m_en", ba.o_m_en, 1'b0);
        chk("t6_rst_m_we", ba.o_m_we, 1'b0);
        chk("t6_rst_m_addr", ba.o_m_addr, 30'd0);
        chk("t6_rst_m_wdata", ba.o_m_wdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        smp();
        chk("t6_first_idle_gnt", ba.o_d_gnt, 1'b1);
        cyc();
        ba.i_d_req = 0;
        for (int i = 1; i <= 5; i++) begin
            smp();
            chk($sformatf("t6_no_f_rvalid_%0d", i), ba.o_f_rvalid, 1'b0);
            chk($sformatf("t6_d_rvalid_%0d", i), ba.o_d_rvalid, (i == 3));
            if (i == 3) chk("t6_d_rdata", ba.o_d_rdata, mem_init(9));
            cyc();
        end

        // randomized traffic against the transaction-level model
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = mem_init(i);
        streak_m = 0; rd_out = 0; rd_d = 0; busy_until = 0; resp_due = 0; acc_at = -1;
        acc_we = 0; acc_word = 0; acc_wdata = 0; fp = 0; dp = 0; f_word = 0; d_word = 0;
        d_we_v = 0; d_wdata_v = 0;
        for (int n = 0; n < 400; n++) begin
            cyc();
            if (fp && $urandom_range(0, 15) == 0) begin
                fp = 0;
            end else if (!fp && $urandom_range(0, 2) == 0) begin
                fp = 1;
                f_word = int'($urandom_range(0, 15));
                ba.i_f_addr = 32'(f_word * 4) + 32'($urandom_range(0, 3));
            end
            if (dp && $urandom_range(0, 15) == 0) begin
                dp = 0;
            end else if (!dp && $urandom_range(0, 1) == 0) begin
                dp = 1;
                d_word = int'($urandom_range(0, 15));
                d_we_v = 1'($urandom_range(0, 1));
                d_wdata_v = $urandom;
                ba.i_d_addr = 32'(d_word * 4) + 32'($urandom_range(0, 3));
                ba.i_d_we = d_we_v;
                ba.i_d_wdata = d_wdata_v;
            end
            ba.i_f_req = fp;
            ba.i_d_req = dp;
            ba.i_f_rready = 1'($urandom_range(0, 1));
            ba.i_d_rready = 1'($urandom_range(0, 1));
            smp();

            free_m   = !rd_out && (n >= busy_until);
            exp_f_rv = rd_out && !rd_d && (n >= resp_due);
            exp_d_rv = rd_out && rd_d && (n >= resp_due);
            chk("rnd_busy", ba.o_busy, !free_m);
            chk("rnd_f_rvalid", ba.o_f_rvalid, exp_f_rv);
            chk("rnd_d_rvalid", ba.o_d_rvalid, exp_d_rv);
            if (exp_f_rv || exp_d_rv) begin
                exp_q.push_back(exp_q.size() > 0 ? exp_q.pop_front() : 32'h0);
            end
            if (exp_f_rv) chk("rnd_f_rdata", ba.o_f_rdata, exp_q[0]);
            if (exp_d_rv) chk("rnd_d_rdata", ba.o_d_rdata, exp_q[0]);
            chk("rnd_m_en", ba.o_m_en, (n == acc_at));
            chk("rnd_m_we", ba.o_m_we, (n == acc_at) && acc_we);
            if (n == acc_at) begin
                chk("rnd_m_addr", ba.o_m_addr, 30'(acc_word));
                if (acc_we) chk("rnd_m_wdata", ba.o_m_wdata, acc_wdata);
            end

            win = 0;
            if (free_m) begin
                if (dp && !(fp && streak_m == SM)) win = 2;
                else if (fp) win = 1;
            end
            chk("rnd_f_gnt", ba.o_f_gnt, (win == 1));
            chk("rnd_d_gnt", ba.o_d_gnt, (win == 2));

            if (win == 2) begin
                acc_at = n + 1; acc_we = d_we_v; acc_word = d_word; acc_wdata = d_wdata_v;
                if (d_we_v) begin
                    ref_mem[d_word] = d_wdata_v;
                    busy_until = n + 2;
                end else begin
                    rd_out = 1; rd_d = 1; resp_due = n + 2 + LAT_A;
                    exp_q.delete();
                    exp_q.push_back(ref_mem[d_word]);
                end
                streak_m = !fp ? 0 : (streak_m == SM ? SM : streak_m + 1);
                dp = 0;
            end else if (win == 1) begin
                acc_at = n + 1; acc_we = 0; acc_word = f_word;
                rd_out = 1; rd_d = 0; resp_due = n + 2 + LAT_A;
                exp_q.delete();
                exp_q.push_back(ref_mem[f_word]);
                streak_m = 0;
                fp = 0;
            end
            if ((exp_f_rv && ba.i_f_rready) || (exp_d_rv && ba.i_d_rready)) begin
                rd_out = 0;
                busy_until = n + 1;
                exp_q.delete();
            end
        end
        ba.i_f_req = 0;
        ba.i_d_req = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/arm32_mem_arbiter.md
Name: arm32_mem_arbiter

Overview:
- Shares the single-port instruction/data RAM of the ARM32 core between two requesters: instruction fetch (read-only) and data load/store.
- Sits between the processor's fetch/memory-access steps and the RAM.
- Sequences each access through a small FSM.
- Data has priority; a starvation guard prevents fetch from being locked out.

Parameters:
AW, 32, requester byte-address width
DW, 32, data width
RD_LAT, 1, RAM read latency in cycles from enable to valid i_m_rdata; legal range 1..7
STARVE_MAX, 4, consecutive data grants allowed while fetch is waiting; legal range 1..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
i_f_req  in  1  fetch request; held with i_f_addr stable until o_f_gnt
i_f_addr  in  AW  fetch byte address
o_f_gnt  out  1  fetch request accepted this cycle
o_f_rvalid  out  1  fetch read data valid
o_f_rdata  out  DW  fetch read data
i_f_rready  in  1  fetch consumer accepts data
i_d_req  in  1  data request; held with other i_d_* stable until o_d_gnt
i_d_we  in  1  1 = store, 0 = load
i_d_addr  in  AW  data byte address
i_d_wdata  in  DW  store data
o_d_gnt  out  1  data request accepted this cycle
o_d_rvalid  out  1  load data valid
o_d_rdata  out  DW  load data
i_d_rready  in  1  data consumer accepts data
o_m_en  out  1  RAM access enable
o_m_we  out  1  RAM write enable
o_m_addr  out  AW-2  RAM word index (byte address [AW-1:2])
o_m_wdata  out  DW  RAM write data
i_m_rdata  in  DW  RAM read data
o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, asserted): FSM=IDLE, streak=0, wait counter=0, all outputs 0 immediately, including o_m_en. An in-flight access is aborted; a write caught mid-ACCESS is not guaranteed to commit. Pending response data is discarded.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - gnt is combinational and only asserted in IDLE.
  - Winner is data if i_d_req and not (i_f_req and streak==STARVE_MAX); otherwise fetch if i_f_req.
  - At most one gnt per cycle.
  - On a grant edge: latch address (low 2 bits dropped), we (fetch forces 0), wdata, owner; go to ACCESS.
- Streak counter:
  - Data grant with i_f_req high: streak+1, saturating at STARVE_MAX.
  - Data grant with i_f_req low: streak=0.
  - Fetch grant: streak=0.
- ACCESS (exactly 1 cycle):
  - Drive o_m_en=1, o_m_we, o_m_addr, o_m_wdata from the latched values.
  - Store: commits this cycle; next state IDLE; no response.
  - Load/fetch: next state WAIT with counter=1.
- WAIT:
  - Stay while counter<RD_LAT, incrementing the counter.
  - When counter==RD_LAT: capture i_m_rdata into the owner's response register; go to RESP.
- RESP:
  - Owner's rvalid=1 and rdata stable until the owner's rready is high.
  - Handshake edge: rvalid drops next cycle; go to IDLE.
  - rready high in the first RESP cycle gives a single-cycle RESP.
  - The non-owner rvalid stays 0 throughout.
- Latency, RD_LAT=1: gnt cycle t, ACCESS t+1, WAIT t+2, RESP from t+3. Next grant no earlier than t+4 with immediate rready. Store: gnt t, write t+1, next grant t+2.
- Requests arriving in non-IDLE states: no gnt; requester holds. Dropping req before gnt is legal and nothing is recorded.
- rready while rvalid=0: ignored.
- o_m_en, o_m_we are 0 outside ACCESS. o_m_addr/o_m_wdata hold their last latched values.
- o_busy = (state != IDLE).

Test Plan:
1. Single fetch, RD_LAT=1, f_addr=0x0000_0010, RAM word 4=0xE3A0_1005, rready=1. Expected: f_gnt cycle 0; m_en=1, m_addr=4, m_we=0 cycle 1; f_rvalid=1, f_rdata=0xE3A0_1005 cycle 3 only.
2. Store then load. Store: d_we=1, d_addr=0x20, wdata=0xDEAD_BEEF gives m_en=m_we=1, m_addr=8 one cycle after gnt, with no d_rvalid. Load from 0x23 then returns d_rdata=0xDEAD_BEEF (misaligned low bits ignored).
3. Simultaneous f_req and d_req every cycle, STARVE_MAX=4, stores only. Expected grant order: D,D,D,D,F,D,D,D,D,F. The streak resets after each F.
4. Backpressure: load, hold d_rready=0 for 5 cycles. Expected: d_rvalid and d_rdata stable 5+ cycles, o_busy=1, f_req gets no gnt. Raise d_rready: rvalid drops next cycle and f_gnt follows the cycle after.
5. RD_LAT=3 fetch. Expected: m_en at t+1, data captured at end of t+4, f_rvalid at t+5.
6. reset asserted in the WAIT state. Expected: same-cycle (async) all outputs 0 and o_busy=0, no rvalid ever issued for the aborted access. After release, a new request is granted in the first IDLE cycle.
